dmem_responder: RTL and testbench

- Data-memory responder for the pipelined CPU's data port. Serves the CPU's `d_addr`/`d_dataout`/`d_we` requests and returns `d_datain`.
- Read is combinational; write is synchronous.
- Adds a byte-serial host loader/debug port, so a bench or board controller can preload and inspect memory through a valid/ready command FSM.
- Sits beside the CPU at top level, with the instruction memory alongside.

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// CPU data-port and host byte-port signals for dmem_responder.
// master = CPU/host side, slave = responder.
interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dataout;
    logic              d_we;
    logic [DATA_W-1:0] d_datain;
    logic              host_in_valid;
    logic [7:0]        host_in_byte;
    logic              host_in_ready;
    logic              host_out_valid;
    logic [7:0]        host_out_byte;
    logic              host_out_ready;

    modport master (
        output d_addr, d_dataout, d_we, host_in_valid, host_in_byte, host_out_ready,
        input  d_datain, host_in_ready, host_out_valid, host_out_byte
    );

    modport slave (
        input  d_addr, d_dataout, d_we, host_in_valid, host_in_byte, host_out_ready,
        output d_datain, host_in_ready, host_out_valid, host_out_byte
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory for the CPU data port plus a byte-serial host load/inspect FSM.
// Optional: `DMEM_WR_COUNT_EN adds a saturating CPU-write counter read by host cmd 8'h40.
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_WHI, S_WLO, S_WCOMMIT, S_RHI, S_RLO
    } state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [DATA_W-1:0]  word;
    logic               is_wr;
    logic               in_fire, out_fire, is_count, commit, in_rdy_st;
    logic [15:0]        cnt_word;

    assign bus.d_datain = mem[bus.d_addr];

    // Ready is gated by reset so the host sees 0 while reset is held.
    assign bus.host_in_ready = in_rdy_st & reset;
    assign in_fire  = bus.host_in_valid & bus.host_in_ready;
    assign out_fire = bus.host_out_valid & bus.host_out_ready;
    assign busy     = (state != S_CMD);

`ifdef DMEM_WR_COUNT_EN
    logic [15:0] wr_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wr_cnt <= '0;
        else if (bus.d_we && wr_cnt != 16'hFFFF)
            wr_cnt <= wr_cnt + 16'd1;
    end

    assign is_count = (bus.host_in_byte == 8'h40);
    assign cnt_word = wr_cnt;
`else
    assign is_count = 1'b0;
    assign cnt_word = 16'h0000;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_CMD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        in_rdy_st          = 1'b0;
        bus.host_out_valid = 1'b0;
        bus.host_out_byte  = 8'h00;
        commit             = 1'b0;
        case (state)
            S_CMD: begin
                in_rdy_st = 1'b1;
                if (in_fire) state_nxt = is_count ? S_RHI : S_ADDR;
            end
            S_ADDR: begin
                in_rdy_st = 1'b1;
                if (in_fire) state_nxt = is_wr ? S_WHI : S_RHI;
            end
            S_WHI: begin
                in_rdy_st = 1'b1;
                if (in_fire) state_nxt = S_WLO;
            end
            S_WLO: begin
                in_rdy_st = 1'b1;
                if (in_fire) state_nxt = S_WCOMMIT;
            end
            S_WCOMMIT: begin
                // CPU store owns the single write port; host write waits.
                if (!bus.d_we) begin
                    commit    = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_RHI: begin
                bus.host_out_valid = 1'b1;
                bus.host_out_byte  = word[15:8];
                if (out_fire) state_nxt = S_RLO;
            end
            S_RLO: begin
                bus.host_out_valid = 1'b1;
                bus.host_out_byte  = word[7:0];
                if (out_fire) state_nxt = S_CMD;
            end
            default: state_nxt = S_CMD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr  <= '0;
            data  <= '0;
            word  <= '0;
            is_wr <= 1'b0;
        end else if (in_fire) begin
            case (state)
                S_CMD: begin
                    is_wr <= bus.host_in_byte[7];
                    if (is_count) word <= cnt_word;
                end
                S_ADDR: begin
                    addr <= bus.host_in_byte[ADDR_W-1:0];
                    // Snapshot now so later CPU stores cannot alter bytes in flight.
                    if (!is_wr) word <= mem[bus.host_in_byte[ADDR_W-1:0]];
                end
                S_WHI:   data[15:8] <= bus.host_in_byte;
                S_WLO:   data[7:0]  <= bus.host_in_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (bus.d_we)
            mem[bus.d_addr] <= bus.d_dataout;
        else if (commit)
            mem[addr] <= data;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand-written corner
// sequences and a randomized mix against a word-array memory model.
module tb_dmem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    dmem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus();

    dmem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] mem_m [256];
    int cnt_m = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] old;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cnt_tick();
        if (cnt_m < 65535) cnt_m++;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] old_exp);
        bus.d_addr = a; bus.d_dataout = d; bus.d_we = 1'b1;
        @(negedge clock);
        chk("cpu_old", bus.d_datain, old_exp);
        @(posedge clock); #1;
        bus.d_we = 1'b0;
        mem_m[a] = d;
        cnt_tick();
        @(negedge clock);
        chk("cpu_new", bus.d_datain, d);
        @(posedge clock); #1;
    endtask

    task automatic cpu_read(input logic [7:0] a, input string name);
        bus.d_addr = a;
        @(negedge clock);
        chk(name, bus.d_datain, mem_m[a]);
        @(posedge clock); #1;
    endtask

    task automatic host_send(input logic [7:0] b);
        int k;
        k = 0;
        bus.host_in_valid = 1'b1; bus.host_in_byte = b;
        @(negedge clock);
        while (!bus.host_in_ready && k < 20) begin
            @(negedge clock); k++;
        end
        if (!bus.host_in_ready) chk("host_in_ready_timeout", 16'(bus.host_in_ready), 16'd1);
        @(posedge clock); #1;
        bus.host_in_valid = 1'b0;
    endtask

    task automatic host_recv(output logic [7:0] b);
        int k;
        k = 0;
        bus.host_out_ready = 1'b1;
        @(negedge clock);
        while (!bus.host_out_valid && k < 20) begin
            @(negedge clock); k++;
        end
        if (!bus.host_out_valid) chk("host_out_valid_timeout", 16'(bus.host_out_valid), 16'd1);
        b = bus.host_out_byte;
        @(posedge clock); #1;
        bus.host_out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clock);
        while (busy && k < 20) begin
            @(negedge clock); k++;
        end
        if (busy) chk("idle_timeout", 16'(busy), 16'd0);
        @(posedge clock); #1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        host_send(8'h80); host_send(a); host_send(d[15:8]); host_send(d[7:0]);
        wait_idle();
        mem_m[a] = d;
    endtask

    task automatic host_read(input logic [7:0] cmd, input logic [7:0] a, input string name);
        logic [7:0] hi, lo;
        host_send(cmd); host_send(a);
        host_recv(hi); host_recv(lo);
        chk(name, {hi, lo}, mem_m[a]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  a, c, hi, lo;
        logic [15:0] d;
        int op;

        bus.d_addr = '0; bus.d_dataout = '0; bus.d_we = 1'b0;
        bus.host_in_valid = 1'b0; bus.host_in_byte = '0; bus.host_out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 16'(bus.host_in_ready), 16'd0);
        chk("rst_out_valid", 16'(bus.host_out_valid), 16'd0);
        chk("rst_out_byte", 16'(bus.host_out_byte), 16'h00);
        chk("rst_busy", 16'(busy), 16'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 16'(bus.host_in_ready), 16'd1);
        @(posedge clock); #1;

        // Preload a known pattern: mem[i] = {A5^i, i}
        for (int i = 0; i < 256; i++) begin
            bus.d_addr = 8'(i); bus.d_dataout = {8'hA5 ^ 8'(i), 8'(i)}; bus.d_we = 1'b1;
            @(posedge clock); #1;
            mem_m[i] = {8'hA5 ^ 8'(i), 8'(i)};
            cnt_tick();
        end
        bus.d_we = 1'b0;

        // CPU write table: old word in the write cycle, new word afterwards
        tbl[0] = '{8'h00, 16'h0000, 16'hA500};
        tbl[1] = '{8'hFF, 16'hFFFF, 16'h5AFF};
        tbl[2] = '{8'h07, 16'hABCD, 16'hA207};
        tbl[3] = '{8'h07, 16'h1357, 16'hABCD};
        tbl[4] = '{8'h80, 16'h8001, 16'h2580};
        tbl[5] = '{8'h3C, 16'h0F0F, 16'h993C};
        for (int i = 0; i < 6; i++) cpu_write(tbl[i].a, tbl[i].d, tbl[i].old);

        // Host write then read back, plus CPU view
        host_write(8'h05, 16'h1234);
        host_send(8'h00); host_send(8'h05);
        host_recv(hi); host_recv(lo);
        chk("tp1_hi", 16'(hi), 16'h0012);
        chk("tp1_lo", 16'(lo), 16'h0034);
        bus.d_addr = 8'h05;
        @(negedge clock);
        chk("tp1_cpu", bus.d_datain, 16'h1234);
        @(posedge clock); #1;

        // CPU stores hold off the host commit
        host_send(8'h80); host_send(8'h09); host_send(8'h55); host_send(8'hAA);
        for (int i = 0; i < 3; i++) begin
            bus.d_we = 1'b1; bus.d_addr = 8'h10 + 8'(i); bus.d_dataout = 16'hC000 + 16'(i);
            @(negedge clock);
            chk("wcommit_hold", 16'(busy), 16'd1);
            @(posedge clock); #1;
            mem_m[8'h10 + 8'(i)] = 16'hC000 + 16'(i);
            cnt_tick();
        end
        bus.d_we = 1'b0;
        wait_idle();
        mem_m[8'h09] = 16'h55AA;
        bus.d_addr = 8'h09;
        @(negedge clock);
        chk("wcommit_mem", bus.d_datain, 16'h55AA);
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) cpu_read(8'h10 + 8'(i), "wcommit_cpu");

        // Response backpressure
        host_send(8'h00); host_send(8'h07);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_valid", 16'(bus.host_out_valid), 16'd1);
            chk("bp_byte", 16'(bus.host_out_byte), 16'(mem_m[8'h07][15:8]));
            @(posedge clock); #1;
        end
        host_recv(hi); host_recv(lo);
        chk("bp_word", {hi, lo}, 16'h1357);

        // Reset in the middle of a host write
        host_send(8'h80); host_send(8'h03); host_send(8'hFF);
        reset = 1'b0;
        #1;
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_out_valid", 16'(bus.host_out_valid), 16'd0);
        chk("mid_in_ready", 16'(bus.host_in_ready), 16'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        cnt_m = 0;
        cpu_read(8'h03, "mid_mem03");
        host_read(8'h00, 8'h03, "mid_next_read");
        host_write(8'h21, 16'hBEEF);
        host_read(8'h01, 8'h21, "mid_next_write");

`ifdef DMEM_WR_COUNT_EN
        for (int i = 0; i < 5; i++) cpu_write(8'h40 + 8'(i), 16'h7000 + 16'(i), mem_m[8'h40 + 8'(i)]);
        host_send(8'h40);
        host_recv(hi); host_recv(lo);
        chk("cnt_hi", 16'(hi), 16'h0000);
        chk("cnt_lo", 16'(lo), 16'h0005);
`else
        host_read(8'h40, 8'h05, "cmd40_read");
`endif

        // Randomized mix against the memory model
        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 3));
            a  = 8'($urandom);
            d  = 16'($urandom);
            case (op)
                0: cpu_write(a, d, mem_m[a]);
                1: cpu_read(a, "rnd_cpu_read");
                2: host_write(a, d);
                default: begin
                    c = 8'($urandom_range(0, 127));
`ifdef DMEM_WR_COUNT_EN
                    if (c == 8'h40) c = 8'h00;
`endif
                    host_read(c, a, "rnd_host_read");
                end
            endcase
        end

`ifdef DMEM_WR_COUNT_EN
        host_send(8'h40);
        host_recv(hi); host_recv(lo);
        chk("rnd_count", {hi, lo}, 16'(cnt_m));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
